// File: rtl/router_pkg.sv
// Shared types and helpers for the length-framed packet router and its channel FIFOs.
package router_pkg;
    typedef enum logic [2:0] {IDLE, DATA, PARITY, CHECK, DROP} state_t;

    // Destination field width; a single bit even when only two channels exist.
    function automatic int addr_width(input int n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

    // FIFO pointer width: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] parity_xor(input logic [31:0] acc, input logic [31:0] b);
        return acc ^ b;
    endfunction
endpackage

// File: rtl/router_chan_fifo.sv
// One output channel: storage, wrap-bit pointers, registered read port, idle-read flush timer.
// Write visible as o_vld after the write edge; read data valid the cycle after a pop.
module router_chan_fifo
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic              i_rd_en,
    output logic              o_full,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_rd_dat
);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int IDX_W = PTR_W - 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_rd_dat;
    logic              w_empty;
    logic              w_rd;
    logic              w_flush;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                      (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
    assign o_vld    = !w_empty;
    assign o_rd_dat = r_rd_dat;
    assign w_rd     = i_rd_en && !w_empty;
    assign w_flush  = o_vld && !i_rd_en && (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= i_wr_dat;
        end
    end

    // A flush drops everything, including a byte written on the same edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_to_cnt <= '0;
            r_rd_dat <= '0;
        end else begin
            if (w_rd) begin
                r_rd_dat <= r_mem[r_rd_ptr[IDX_W-1:0]];
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_to_cnt <= '0;
            end else begin
                if (i_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_empty || i_rd_en) begin
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pkt_router_n.sv
// Steers length-prefixed packets into N_CH channel FIFOs; one byte/cycle plus a CHECK bubble.
// o_busy stalls the source on a full destination FIFO and during CHECK.
module pkt_router_n
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int N_CH    = 3,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_pkt_valid,
    input  logic [DATA_W-1:0]      i_data_in,
    output logic                   o_busy,
    output logic                   o_err,
    input  logic [N_CH-1:0]        i_read_enb,
    output logic [N_CH-1:0]        o_vld_out,
    output logic [N_CH*DATA_W-1:0] o_data_out,
    output logic                   o_drop
);
    localparam int ADDR_W = addr_width(N_CH);
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int NPAD   = 2 ** ADDR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_dest;
    logic [LEN_W-1:0]  r_len_cnt;
    logic [DATA_W-1:0] r_parity;
    logic              r_err;
    logic              r_drop;

    logic [ADDR_W-1:0] w_hdr_addr;
    logic [LEN_W-1:0]  w_hdr_len;
    logic              w_addr_ok;
    logic              w_hdr_ok;
    logic              w_acc;
    logic [N_CH-1:0]   w_full;
    logic [NPAD-1:0]   w_full_pad;
    logic [N_CH-1:0]   w_wr_en;

    assign w_hdr_addr = i_data_in[ADDR_W-1:0];
    assign w_hdr_len  = i_data_in[DATA_W-1:ADDR_W];
    assign w_addr_ok  = (int'(w_hdr_addr) < N_CH);
    assign w_hdr_ok   = w_addr_ok && (w_hdr_len != '0);
    assign w_full_pad = NPAD'(w_full);
    assign w_acc      = i_pkt_valid && !o_busy;
    assign o_err      = r_err;
    assign o_drop     = r_drop;

    always_comb begin
        o_busy = 1'b0;
        case (r_state)
            IDLE:         o_busy = i_pkt_valid && w_addr_ok && w_full_pad[w_hdr_addr];
            DATA, PARITY: o_busy = w_full_pad[r_dest];
            CHECK:        o_busy = 1'b1;
            default:      o_busy = 1'b0;
        endcase
    end

    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_ch
            assign w_wr_en[c] = w_acc &&
                ((r_state == IDLE && w_hdr_ok && w_hdr_addr == ADDR_W'(c)) ||
                 ((r_state == DATA || r_state == PARITY) && r_dest == ADDR_W'(c)));

            router_chan_fifo #(
                .DATA_W  (DATA_W),
                .DEPTH   (DEPTH),
                .TIMEOUT (TIMEOUT)
            ) u_fifo (
                .i_clock  (i_clock),
                .i_reset  (i_reset),
                .i_wr_en  (w_wr_en[c]),
                .i_wr_dat (i_data_in),
                .i_rd_en  (i_read_enb[c]),
                .o_full   (w_full[c]),
                .o_vld    (o_vld_out[c]),
                .o_rd_dat (o_data_out[c*DATA_W +: DATA_W])
            );
        end
    endgenerate

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_dest    <= '0;
            r_len_cnt <= '0;
            r_parity  <= '0;
            r_err     <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                IDLE: if (w_acc) begin
                    r_len_cnt <= w_hdr_len;
                    if (!w_hdr_ok) begin
                        r_drop  <= 1'b1;
                        r_state <= DROP;
                    end else begin
                        r_dest   <= w_hdr_addr;
                        r_parity <= i_data_in;
                        r_state  <= DATA;
                    end
                end
                DATA: if (w_acc) begin
                    r_parity  <= DATA_W'(parity_xor(32'(r_parity), 32'(i_data_in)));
                    r_len_cnt <= r_len_cnt - 1'b1;
                    if (r_len_cnt == LEN_W'(1)) begin
                        r_state <= PARITY;
                    end
                end
                // err is registered here so it is high exactly during CHECK.
                PARITY: if (w_acc) begin
                    r_err   <= (i_data_in != r_parity);
                    r_state <= CHECK;
                end
                CHECK: r_state <= IDLE;
                DROP: if (w_acc) begin
                    if (r_len_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_len_cnt <= r_len_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_router_n.sv
// Bench for pkt_router_n: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_pkt_router_n;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pv  = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [2:0]  rd  = 3'b000;
    logic        busy, err, drop;
    logic [2:0]  vld;
    logic [23:0] dout;

    pkt_router_n #(.DATA_W(8), .N_CH(3), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_pkt_valid(pv),
        .i_data_in  (din),
        .o_busy     (busy),
        .o_err      (err),
        .i_read_enb (rd),
        .o_vld_out  (vld),
        .o_data_out (dout),
        .o_drop     (drop)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pv = 1'b0; din = 8'h00; rd = 3'b000;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         pv;
        logic [7:0] d;
        logic [2:0] rd;
        bit         busy;
        bit         err;
        bit         drop;
        logic [2:0] vld;
        bit         chk;
        logic [7:0] dout1;
    } vec_t;

    function automatic vec_t mk(bit p, logic [7:0] d, logic [2:0] r, bit b, bit e, bit dr,
                                logic [2:0] v, bit c, logic [7:0] o);
        vec_t t;
        t.pv = p; t.d = d; t.rd = r; t.busy = b; t.err = e; t.drop = dr;
        t.vld = v; t.chk = c; t.dout1 = o;
        return t;
    endfunction

    typedef struct {
        logic [7:0] b;
        int         ch;
        int         gate;
        bit         is_hdr;
        bit         hdr_drop;
        bit         last;
        bit         bad;
    } ent_t;

    ent_t       stream[$];
    logic [7:0] mq [3][$];
    int         mcnt [3];
    logic [7:0] exp_lane [3];

    task automatic gen_pkt();
        int         dest, len;
        logic [7:0] hdr, par, b;
        bit         bad;
        ent_t       e;
        dest = $urandom_range(0, 3);
        len  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30) : $urandom_range(0, 5);
        hdr  = 8'((len << 2) | dest);
        e.b = hdr; e.is_hdr = 1'b1; e.last = 1'b0; e.bad = 1'b0;
        e.gate = (dest < 3) ? dest : -1;
        if (dest < 3 && len != 0) begin
            e.ch = dest; e.hdr_drop = 1'b0;
            stream.push_back(e);
            par = hdr;
            e.is_hdr = 1'b0;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                par = par ^ b;
                e.b = b;
                stream.push_back(e);
            end
            bad = ($urandom_range(0, 3) == 0);
            e.b = bad ? (par ^ (8'd1 << $urandom_range(0, 7))) : par;
            e.last = 1'b1; e.bad = bad;
            stream.push_back(e);
        end else begin
            e.ch = -1; e.hdr_drop = 1'b1;
            stream.push_back(e);
            e.is_hdr = 1'b0; e.hdr_drop = 1'b0; e.gate = -1;
            for (int i = 0; i <= len; i++) begin
                e.b = 8'($urandom);
                stream.push_back(e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[$];
        logic [7:0] fill[16];
        logic [7:0] drain_exp[16];
        logic [7:0] par;
        logic [2:0] ev;
        bit         busy_m, acc, in_chk, hold, exp_err, exp_drop, nxt_chk, ne;
        bit         fl [3];
        ent_t       e;
        int         g;

        // Packet to ch1 (0D 11 22 33, parity 0D), read back; same packet with bad parity; dropped header.
        vecs.push_back(mk(1, 8'h0D, 3'b000, 0, 0, 0, 3'b000, 0, 8'h00));
        vecs.push_back(mk(1, 8'h11, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(1, 8'h22, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(1, 8'h33, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(1, 8'h0D, 3'b000, 0, 0, 0, 3'b010, 1, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 1, 8'h0D));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 1, 8'h11));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 1, 8'h22));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 1, 8'h33));
        vecs.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 3'b000, 1, 8'h0D));
        vecs.push_back(mk(1, 8'h0D, 3'b000, 0, 0, 0, 3'b000, 1, 8'h0D));
        vecs.push_back(mk(1, 8'h11, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(1, 8'h22, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(1, 8'h33, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(1, 8'h00, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b000, 1, 1, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(1, 8'h07, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(1, 8'hAA, 3'b000, 0, 0, 1, 3'b010, 0, 8'h00));
        vecs.push_back(mk(1, 8'hBB, 3'b000, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 3'b010, 1, 8'h0D));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 1, 8'h0D));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 1, 8'h11));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 1, 8'h22));
        vecs.push_back(mk(0, 8'h00, 3'b010, 0, 0, 0, 3'b010, 1, 8'h33));
        vecs.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 3'b000, 1, 8'h00));

        do_reset();
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err",  32'(err),  0);
        chk("reset_drop", 32'(drop), 0);
        chk("reset_vld",  32'(vld),  0);
        chk("reset_dout", 32'(dout), 0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            pv = vecs[i].pv; din = vecs[i].d; rd = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_err", i),  32'(err),  32'(vecs[i].err));
            chk($sformatf("vec%0d_drop", i), 32'(drop), 32'(vecs[i].drop));
            chk($sformatf("vec%0d_vld", i),  32'(vld),  32'(vecs[i].vld));
            if (vecs[i].chk) chk($sformatf("vec%0d_dout1", i), 32'(dout[15:8]), 32'(vecs[i].dout1));
            cyc();
        end

        // Fill ch2 to DEPTH, then a held header stalls until one read frees a slot.
        do_reset();
        par = 8'h3A;
        fill[0] = 8'h3A;
        for (int i = 1; i <= 14; i++) begin
            fill[i] = 8'(8'h40 + i);
            par = par ^ fill[i];
        end
        fill[15] = par;
        for (int i = 0; i < 15; i++) drain_exp[i] = fill[i + 1];
        drain_exp[15] = 8'h06;
        for (int i = 0; i < 16; i++) begin
            pv = 1'b1; din = fill[i];
            @(negedge clk);
            chk($sformatf("fill%0d_busy", i), 32'(busy), 0);
            cyc();
        end
        din = 8'h06;
        @(negedge clk); chk("fill_check_busy", 32'(busy), 1); cyc();
        @(negedge clk); chk("full_busy", 32'(busy), 1); chk("full_vld2", 32'(vld[2]), 1); cyc();
        rd = 3'b100;
        @(negedge clk); chk("full_busy_rd", 32'(busy), 1); cyc();
        rd = 3'b000;
        @(negedge clk); chk("busy_release", 32'(busy), 0); chk("full_first_rd", 32'(dout[23:16]), 8'h3A); cyc();
        pv = 1'b0;
        for (int k = 0; k < 16; k++) begin
            rd = 3'b100;
            cyc();
            @(negedge clk);
            chk($sformatf("drain%0d", k), 32'(dout[23:16]), 32'(drain_exp[k]));
        end
        rd = 3'b000;
        cyc();
        @(negedge clk); chk("drain_empty", 32'(vld[2]), 0);
        cyc();

        // Unread ch0 flushes after TIMEOUT cycles.
        do_reset();
        pv = 1'b1; din = 8'h04; cyc();
        din = 8'h5A; cyc();
        din = 8'h5E; cyc();
        pv = 1'b0;
        for (int n = 3; n <= 31; n++) begin
            @(negedge clk);
            if (n == 30) chk("to_vld_before", 32'(vld[0]), 1);
            if (n == 31) begin
                chk("to_vld_after", 32'(vld[0]), 0);
                chk("to_dout_kept", 32'(dout[7:0]), 0);
            end
            cyc();
        end

        // A read just before expiry restarts the count.
        do_reset();
        pv = 1'b1; din = 8'h04; cyc();
        din = 8'h5A; cyc();
        din = 8'h5E; cyc();
        pv = 1'b0;
        for (int n = 3; n <= 60; n++) begin
            rd = (n == 29) ? 3'b001 : 3'b000;
            @(negedge clk);
            if (n == 31) chk("to_restart_31", 32'(vld[0]), 1);
            if (n == 59) chk("to_restart_59", 32'(vld[0]), 1);
            if (n == 60) begin
                chk("to_restart_60", 32'(vld[0]), 0);
                chk("to_restart_dout", 32'(dout[7:0]), 8'h04);
            end
            cyc();
        end
        rd = 3'b000;

        // Reset in DATA, then a fresh packet.
        do_reset();
        pv = 1'b1; din = 8'h0D; cyc();
        din = 8'h11; cyc();
        din = 8'h22;
        chk("mid_pre_vld", 32'(vld), 3'b010);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld",  32'(vld),  0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        din = 8'h04; cyc();
        din = 8'h5A; cyc();
        din = 8'h5E; cyc();
        pv = 1'b0;
        @(negedge clk); chk("mid_new_check", 32'(busy), 1); cyc();
        @(negedge clk); chk("mid_new_vld", 32'(vld), 3'b001); chk("mid_new_err", 32'(err), 0);
        rd = 3'b001; cyc();
        rd = 3'b000;
        @(negedge clk); chk("mid_new_dout", 32'(dout[7:0]), 8'h04);
        cyc();

        // Random traffic against the queue model.
        do_reset();
        stream.delete();
        for (int c = 0; c < 3; c++) begin
            mq[c].delete(); mcnt[c] = 0; exp_lane[c] = 8'h00;
        end
        in_chk = 1'b0; hold = 1'b0; exp_err = 1'b0; exp_drop = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (stream.size() == 0) gen_pkt();
            pv  = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            din = stream[0].b;
            for (int c = 0; c < 3; c++) rd[c] = ($urandom_range(0, 3) == 0);
            busy_m = in_chk;
            g = stream[0].gate;
            if (!in_chk && g >= 0) begin
                if (mq[g].size() == DEPTH && (!stream[0].is_hdr || pv)) busy_m = 1'b1;
            end
            for (int c = 0; c < 3; c++) ev[c] = (mq[c].size() != 0);
            @(negedge clk);
            chk($sformatf("rnd%0d_busy", t), 32'(busy), 32'(busy_m));
            chk($sformatf("rnd%0d_vld", t),  32'(vld),  32'(ev));
            chk($sformatf("rnd%0d_err", t),  32'(err),  32'(exp_err));
            chk($sformatf("rnd%0d_drop", t), 32'(drop), 32'(exp_drop));
            chk($sformatf("rnd%0d_dout", t), 32'(dout), 32'({exp_lane[2], exp_lane[1], exp_lane[0]}));
            acc = pv && !busy_m;
            for (int c = 0; c < 3; c++) begin
                ne = (mq[c].size() != 0);
                fl[c] = ne && !rd[c] && (mcnt[c] == TIMEOUT - 1);
                if (ne && rd[c]) exp_lane[c] = mq[c].pop_front();
                if (fl[c]) begin
                    mq[c].delete();
                    mcnt[c] = 0;
                end else if (!ne || rd[c]) begin
                    mcnt[c] = 0;
                end else begin
                    mcnt[c]++;
                end
            end
            exp_err = 1'b0; exp_drop = 1'b0; nxt_chk = 1'b0;
            if (acc) begin
                e = stream.pop_front();
                if (e.ch >= 0) begin
                    if (!fl[e.ch]) mq[e.ch].push_back(e.b);
                end
                if (e.hdr_drop) exp_drop = 1'b1;
                if (e.last) begin
                    nxt_chk = 1'b1;
                    exp_err = e.bad;
                end
            end
            in_chk = nxt_chk;
            hold = pv && busy_m;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
